// File: rtl/booth_issue_ctrl_if.sv
// booth_issue_ctrl_if
//   Groups the operand input handshake, the multiplier-core drive/sample
//   signals, the result output handshake and the status outputs of
//   booth_issue_ctrl.
//   slave  : the controller's view (booth_issue_ctrl port)
//   master : the environment's view (upstream source, core, downstream sink)
// Ports:
//   in_valid/in_ready/in_mcand/in_mplier  operand pair push
//   mul_rst_n/mul_mcand/mul_mplier         drive to multiplier core
//   mul_product                            product sampled from the core
//   out_valid/out_ready/out_product        result handshake
//   busy/fifo_count                        status
interface booth_issue_ctrl_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_mcand;
    logic [3:0]    in_mplier;
    logic          mul_rst_n;
    logic [7:0]    mul_mcand;
    logic [3:0]    mul_mplier;
    logic [8:0]    mul_product;
    logic          out_valid;
    logic          out_ready;
    logic [8:0]    out_product;
    logic          busy;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  in_valid, in_mcand, in_mplier, mul_product, out_ready,
        output in_ready, mul_rst_n, mul_mcand, mul_mplier,
               out_valid, out_product, busy, fifo_count
    );

    modport master (
        output in_valid, in_mcand, in_mplier, mul_product, out_ready,
        input  in_ready, mul_rst_n, mul_mcand, mul_mplier,
               out_valid, out_product, busy, fifo_count
    );
endinterface

// File: rtl/booth_issue_ctrl.sv
// booth_issue_ctrl
//   Buffers operand pairs in a small circular FIFO and issues them one at a
//   time to an external fixed-latency multiplier core. Each issue pulses the
//   core's active-low restart for one cycle, holds the operands stable for
//   MUL_LATENCY cycles, samples the product and presents it on a
//   valid/ready output that is held until accepted.
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-low reset
//   bus   booth_issue_ctrl_if.slave (operand push, core drive, result, status)
module booth_issue_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int MUL_LATENCY = 8
)(
    input  logic               clk,
    input  logic               rst,
    booth_issue_ctrl_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] CNT_LOAD = TW'(MUL_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [11:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [TW-1:0] r_cnt;
    logic [7:0]    r_mcand;
    logic [3:0]    r_mplier;
    logic          r_mul_rst_n;
    logic          r_out_valid;
    logic [8:0]    r_out_product;

    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_capture;

    // in_ready looks only at the occupancy, so a full FIFO stays closed even
    // in a cycle where the FSM is popping.
    assign w_in_ready = (r_count < DEPTH_C);
    assign w_push     = bus.in_valid && w_in_ready;
    // Pop only from a registered count: a push into an empty FIFO is seen by
    // the FSM one cycle later.
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_capture  = (r_state == S_WAIT) && (r_cnt == '0);

    // ---------------- operand FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.in_mcand, bus.in_mplier};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- issue FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_count != '0) w_state_nxt = S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT:   if (r_cnt == '0)   w_state_nxt = S_HOLD;
            S_HOLD:   if (bus.out_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt         <= '0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_mul_rst_n   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
        end else begin
            // Registered restart: low exactly while the FSM sits in LAUNCH,
            // and high from the first edge after reset release.
            r_mul_rst_n <= (w_state_nxt != S_LAUNCH);

            if (w_pop) begin
                r_mcand  <= r_mem[r_rptr][11:4];
                r_mplier <= r_mem[r_rptr][3:0];
            end

            if (r_state == S_LAUNCH)                 r_cnt <= CNT_LOAD;
            else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;

            if (w_capture) begin
                r_out_valid   <= 1'b1;
                r_out_product <= bus.mul_product;
            end else if (r_state == S_HOLD && bus.out_ready) begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.mul_rst_n   = r_mul_rst_n;
    assign bus.mul_mcand   = r_mcand;
    assign bus.mul_mplier  = r_mplier;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_product = r_out_product;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.fifo_count  = r_count;
endmodule

// File: tb/tb_booth_issue_ctrl.sv
// tb_booth_issue_ctrl
//   Randomized and directed stimulus for booth_issue_ctrl, checked every cycle
//   against a transaction-level model (queue of pending pairs, one in-flight
//   operation with an age in cycles since issue) plus literal expectations.
module tb_booth_issue_ctrl;
    localparam int DEPTH = 4;
    localparam int LAT   = 8;

    logic clk;
    logic rst;

    booth_issue_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus();

    booth_issue_ctrl #(.FIFO_DEPTH(DEPTH), .MUL_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit prod_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [11:0] q[$];
    bit          m_inflight = 1'b0;
    int          m_age      = 0;
    bit          m_ov       = 1'b0;
    logic [8:0]  m_prod     = '0;
    logic [7:0]  m_mc       = '0;
    logic [3:0]  m_mp       = '0;
    bit          m_started  = 1'b0;
    int          m_hs       = 0;
    bit          m_do_push;
    bit          m_do_pop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_inflight = 1'b0;
            m_age      = 0;
            m_ov       = 1'b0;
            m_prod     = '0;
            m_mc       = '0;
            m_mp       = '0;
            m_started  = 1'b0;
        end else begin
            m_do_push = bus.in_valid && (q.size() < DEPTH);
            m_do_pop  = !m_inflight && (q.size() > 0);
            m_started = 1'b1;
            if (m_inflight) begin
                if (m_ov) begin
                    if (bus.out_ready) begin
                        m_ov       = 1'b0;
                        m_inflight = 1'b0;
                        m_hs++;
                    end
                end else begin
                    m_age++;
                    if (m_age == LAT + 1) begin
                        m_ov   = 1'b1;
                        m_prod = bus.mul_product;
                    end
                end
            end
            if (m_do_pop) begin
                m_mc       = q[0][11:4];
                m_mp       = q[0][3:0];
                void'(q.pop_front());
                m_inflight = 1'b1;
                m_age      = 0;
            end
            if (m_do_push) q.push_back({bus.in_mcand, bus.in_mplier});
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",    bus.in_ready,    (q.size() < DEPTH));
            chk("fifo_count",  bus.fifo_count,  q.size());
            chk("busy",        bus.busy,        m_inflight);
            chk("mul_rst_n",   bus.mul_rst_n,   m_started && !(m_inflight && m_age == 0));
            chk("mul_mcand",   bus.mul_mcand,   m_mc);
            chk("mul_mplier",  bus.mul_mplier,  m_mp);
            chk("out_valid",   bus.out_valid,   m_ov);
            chk("out_product", bus.out_product, m_prod);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance one edge; inputs change 1 time unit after the edge. The core
    // stub returns either the true product of the model's held operands or
    // per-cycle random noise (so a capture at the wrong cycle is visible).
    task automatic step();
        logic [11:0] pr;
        @(posedge clk);
        #1;
        if (prod_rand) begin
            bus.mul_product = 9'($urandom);
        end else begin
            pr = {4'b0, m_mc} * {8'b0, m_mp};
            bus.mul_product = pr[8:0];
        end
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((m_inflight || q.size() != 0) && n < max_cyc) begin
            step();
            n++;
        end
        chk(name, (m_inflight || q.size() != 0), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},    bus.in_ready,    1);
        chk({tag, "_fifo_count"},  bus.fifo_count,  0);
        chk({tag, "_busy"},        bus.busy,        0);
        chk({tag, "_mul_rst_n"},   bus.mul_rst_n,   0);
        chk({tag, "_out_valid"},   bus.out_valid,   0);
        chk({tag, "_out_product"}, bus.out_product, 0);
        chk({tag, "_mul_mcand"},   bus.mul_mcand,   0);
        chk({tag, "_mul_mplier"},  bus.mul_mplier,  0);
    endtask

    int acc;
    int hs0;
    int n;
    bit found;

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_mcand    = '0;
        bus.in_mplier   = '0;
        bus.mul_product = '0;
        bus.out_ready   = 1'b0;

        // Reset state, asynchronously before any clock edge
        #2 rst = 1'b0;
        #1 check_reset_vals("rst0");
        chk_en = 1'b1;
        repeat (2) step();
        rst = 1'b1;

        // Single op: (25,3) with a true-product stub -> 75 at edge 9 after pop
        bus.in_valid  = 1'b1;
        bus.in_mcand  = 8'd25;
        bus.in_mplier = 4'd3;
        bus.out_ready = 1'b1;
        step();                         // push edge
        bus.in_valid = 1'b0;
        step();                         // pop edge
        chk("single_pop_mcand",  bus.mul_mcand,  25);
        chk("single_pop_mplier", bus.mul_mplier, 3);
        chk("single_restart_lo", bus.mul_rst_n,  0);
        chk("single_busy",       bus.busy,       1);
        for (int k = 1; k <= LAT; k++) step();
        chk("single_not_early",  bus.out_valid,  0);
        chk("single_restart_hi", bus.mul_rst_n,  1);
        step();
        chk("single_valid",      bus.out_valid,  1);
        chk("single_product",    bus.out_product, 75);
        step();                         // handshake edge
        chk("single_done",       bus.out_valid,  0);
        chk("single_idle",       bus.busy,       0);

        // Fill with output blocked: 6 back-to-back offers, 5 accepted
        bus.out_ready = 1'b0;
        acc = 0;
        hs0 = m_hs;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_mcand  = 8'(10 + i);
            bus.in_mplier = 4'(i + 1);
            if (bus.in_ready) acc++;
            step();
        end
        bus.in_valid = 1'b0;
        chk("fill_accepted", acc, 5);
        chk("fill_count",    bus.fifo_count, 4);
        chk("fill_in_ready", bus.in_ready, 0);

        // Backpressure: 20 cycles in HOLD, nothing moves
        n = 0;
        while (!m_ov && n < 40) begin step(); n++; end
        chk("hold_reached", m_ov, 1);
        for (int i = 0; i < 20; i++) step();
        chk("hold_valid",   bus.out_valid,   1);
        chk("hold_product", bus.out_product, 10);
        chk("hold_mcand",   bus.mul_mcand,   10);
        chk("hold_count",   bus.fifo_count,  4);
        drain("fill_drain", 200);
        chk("fill_results", m_hs - hs0, 5);

        // Randomized traffic: wrap, simultaneous push/pop, random backpressure
        prod_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid  = ($urandom_range(0, 99) < 55);
            bus.in_mcand  = 8'($urandom);
            bus.in_mplier = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 99) < 60);
            step();
        end
        drain("rand_drain", 200);

        // Reset at WAIT counter = 3 (age 5) with 2 entries queued
        prod_rand     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_mcand  = 8'(40 + i);
            bus.in_mplier = 4'(i + 5);
            step();
        end
        bus.in_valid = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            if (m_inflight && m_age == 5 && q.size() == 2) found = 1'b1;
            else begin step(); n++; end
        end
        chk("rst_point_found", found, 1);
        #2 rst = 1'b0;
        #1 check_reset_vals("rst_mid");
        repeat (2) step();
        rst = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("post_rst_no_result", bus.out_valid, 0);
        chk("post_rst_idle",      bus.busy,      0);

        // New work after reset still flows
        bus.in_valid  = 1'b1;
        bus.in_mcand  = 8'd7;
        bus.in_mplier = 4'd9;
        step();
        drain("post_rst_drain", 60);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/booth_issue_ctrl.md
BOOTH_ISSUE_CTRL -- requirements
Module: booth_issue_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, operand FIFO entries (power of two, >=2).
REQ-002 Parameter: MUL_LATENCY, 8, cycles operands are held before product is sampled (>=1).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  FIFO can accept; transfer on in_valid && in_ready at clk edge.
REQ-007 in_mcand  input  8  multiplicand.
REQ-008 in_mplier  input  4  multiplier.
REQ-009 mul_rst_n  output  1  active-low restart to multiplier core.
REQ-010 mul_mcand  output  8  multiplicand driven to multiplier core.
REQ-011 mul_mplier  output  4  multiplier driven to multiplier core.
REQ-012 mul_product  input  9  product from multiplier core.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts; transfer on out_valid && out_ready.
REQ-015 out_product  output  9  captured product.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-018 FIFO: circular, FIFO_DEPTH entries of {mcand[7:0], mplier[3:0]}; read/write pointers wrap modulo FIFO_DEPTH.
REQ-019 in_ready = (fifo_count < FIFO_DEPTH), combinational from count only; a same-cycle pop does not raise in_ready when full.
REQ-020 Push while empty: entry visible to FSM next cycle (no fall-through).
REQ-021 Simultaneous push and pop: fifo_count unchanged, both pointers advance.
REQ-022 FSM states IDLE, LAUNCH, WAIT, HOLD.
REQ-023 IDLE: if fifo_count != 0, pop head into mul_mcand/mul_mplier registers, go LAUNCH; else stay.
REQ-024 LAUNCH: mul_rst_n = 0 for exactly this one cycle; load counter = MUL_LATENCY-1; go WAIT.
REQ-025 WAIT: mul_rst_n = 1; if counter == 0, capture mul_product into out_product, set out_valid, go HOLD; else decrement.
REQ-026 HOLD: out_valid stays 1 and out_product stable until out_ready; on handshake clear out_valid, go IDLE.
REQ-027 Latency: out_valid rises MUL_LATENCY+1 clock edges after the pop edge; next pop no earlier than the edge after the output handshake.
REQ-028 mul_mcand/mul_mplier stable from pop until next pop; never change in LAUNCH, WAIT, HOLD.
REQ-029 out_product changes only at capture; no arithmetic performed on mul_product (9-bit pass-through).
REQ-030 Pushes accepted in all FSM states subject to REQ-019.

Reset
REQ-031 rst low: immediately (asynchronous) state = IDLE, FIFO pointers and fifo_count = 0, counter = 0, out_valid = 0, out_product = 0, mul_mcand = 0, mul_mplier = 0, mul_rst_n = 0, busy = 0, in_ready = 1 (combinational: fifo_count 0 < FIFO_DEPTH).
REQ-032 mul_rst_n returns to 1 on the first clk edge after rst deasserts; rst deasserted while in_valid high: no push occurs before that first edge.
REQ-033 Reset mid-WAIT or mid-HOLD discards the in-flight operation and all FIFO contents; no out_valid produced for them.

Verification
REQ-034 Single op: push (25, 3), out_ready = 1, core stub returns 9'd75 -> mul_rst_n low one cycle after pop; out_valid with out_product = 75 at edge 9 after pop (MUL_LATENCY = 8).
REQ-035 Fill: out_ready = 0, push 6 pairs back-to-back -> 5 accepted (1 in flight + 4 queued), in_ready = 0 with fifo_count = 4; release out_ready -> 5 results in push order.
REQ-036 Backpressure: out_ready = 0 for 20 cycles in HOLD -> out_valid and out_product unchanged, mul_mcand/mul_mplier unchanged, no pop.
REQ-037 Simultaneous push/pop at fifo_count = 2 -> count stays 2; pointer wrap exercised over 10 ops with correct ordering.
REQ-038 Reset asserted at WAIT counter = 3 with 2 entries queued -> all outputs at REQ-031 values asynchronously; after release no result emitted until new push.
